// File: rtl/bram_playback.sv
// Purpose: replays words 0..len-1 of a BRAM as an AXI-Stream, num_passes times (0 = until stop).
// Latency: first read the cycle after start, first m_tvalid two cycles after start, then 1 beat/cycle.
// Backpressure: at most two words buffered or in flight; reads pause while m_tready holds the stream.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   start, stop             one-cycle control pulses
//   len, num_passes         run setup, captured on an accepted start
//   mem_en/mem_addr         read port to a 1-cycle-latency memory; mem_dout returns the data
//   m_tdata/m_tvalid/m_tready/m_tlast   AXI-Stream output
//   busy, done, pass_cnt    status

// Small generic FIFO. When empty, a pushed word is presented on the output in
// the same cycle (bypass), so a 1-cycle memory can still sustain 1 beat/cycle.
module bram_playback_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push_vld,
  input  logic [WIDTH-1:0]           i_push_dat,
  output logic                       o_pop_vld,
  output logic [WIDTH-1:0]           o_pop_dat,
  input  logic                       i_pop_rdy,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_empty;
  logic             w_bypass;
  logic             w_wr;
  logic             w_rd;

  assign w_empty   = (r_count == '0);
  assign o_pop_vld = !w_empty || i_push_vld;
  // Output is forced to zero when nothing is valid so idle/reset data reads 0.
  assign o_pop_dat = !w_empty  ? r_mem[r_rd_ptr] :
                     i_push_vld ? i_push_dat     : '0;
  // A word that arrives into an empty FIFO and leaves at once is never stored.
  assign w_bypass  = w_empty && i_push_vld && i_pop_rdy;
  assign w_wr      = i_push_vld && !w_bypass;
  assign w_rd      = !w_empty && i_pop_rdy;
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, w_rd};
    end
  end
endmodule

module bram_playback #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [AWIDTH:0]   len,
  input  logic [15:0]       num_passes,
  output logic              mem_en,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt
);
  localparam logic [AWIDTH:0] LEN_MAX = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH:0]   r_len;
  logic [15:0]       r_num_passes;
  logic              r_stop;
  logic [AWIDTH-1:0] r_addr;
  logic [15:0]       r_passes_issued;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_inflight_final;
  logic [15:0]       r_pass_cnt;
  logic              r_done;

  logic              w_accept;
  logic              w_issue;
  logic              w_room;
  logic              w_at_end;
  logic              w_final_pass;
  logic [AWIDTH:0]   w_len_clamped;
  logic [AWIDTH:0]   w_last_addr;
  logic              w_head_vld;
  logic [DWIDTH+1:0] w_head_dat;
  logic              w_head_final;
  logic              w_head_last;
  logic              w_beat;
  logic [1:0]        w_fifo_count;

  assign w_len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_last_addr   = r_len - (AWIDTH + 1)'(1);
  assign w_at_end      = ({1'b0, r_addr} == w_last_addr);
  // A pass ends the run if stop was seen (latched or arriving now) or the pass budget is used up.
  assign w_final_pass  = r_stop || stop ||
                         ((r_num_passes != 16'd0) && (r_passes_issued == r_num_passes - 16'd1));
  // Buffered words plus the read in flight must stay below two before a new read issues.
  assign w_room        = (w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && !r_inflight);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (len != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = w_room;
        if (w_room && w_at_end && w_final_pass) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_beat && w_head_final) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_len            <= '0;
      r_num_passes     <= '0;
      r_stop           <= 1'b0;
      r_addr           <= '0;
      r_passes_issued  <= '0;
      r_inflight       <= 1'b0;
      r_inflight_last  <= 1'b0;
      r_inflight_final <= 1'b0;
      r_pass_cnt       <= '0;
      r_done           <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_done           <= w_beat && w_head_final;
      r_inflight       <= w_issue;
      r_inflight_last  <= w_issue && w_at_end;
      r_inflight_final <= w_issue && w_at_end && w_final_pass;
      if (w_accept) begin
        r_len           <= w_len_clamped;
        r_num_passes    <= num_passes;
        r_stop          <= stop;
        r_addr          <= '0;
        r_passes_issued <= '0;
        r_pass_cnt      <= '0;
      end else begin
        if ((r_state == S_RUN) && stop) r_stop <= 1'b1;
        if (w_issue) begin
          r_addr <= w_at_end ? '0 : r_addr + AWIDTH'(1);
          if (w_at_end) r_passes_issued <= r_passes_issued + 16'd1;
        end
        if (w_beat && w_head_last && (r_pass_cnt != 16'hFFFF)) r_pass_cnt <= r_pass_cnt + 16'd1;
      end
    end
  end

  // Each word carries its tlast flag and a flag marking the very last beat of the run.
  bram_playback_fifo #(
    .WIDTH (DWIDTH + 2),
    .DEPTH (2)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (r_inflight),
    .i_push_dat ({r_inflight_final, r_inflight_last, mem_dout}),
    .o_pop_vld  (w_head_vld),
    .o_pop_dat  (w_head_dat),
    .i_pop_rdy  (m_tready),
    .o_count    (w_fifo_count)
  );

  assign w_head_final = w_head_dat[DWIDTH+1];
  assign w_head_last  = w_head_dat[DWIDTH];
  assign w_beat       = w_head_vld && m_tready;

  assign mem_en   = w_issue;
  assign mem_addr = r_addr;
  assign m_tdata  = w_head_dat[DWIDTH-1:0];
  assign m_tlast  = w_head_last;
  assign m_tvalid = w_head_vld;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign pass_cnt = r_pass_cnt;
endmodule

// File: tb/tb_bram_playback.sv
module tb_bram_playback;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop;
  logic [AW:0]   len;
  logic [15:0]   num_passes;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic          busy, done;
  logic [15:0]   pass_cnt;

  bram_playback #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .len(len),
    .num_passes(num_passes), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .done(done),
    .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  // Memory contents; read data is only meaningful one cycle after mem_en.
  logic [DW-1:0] bmem [1 << AW];
  always @(posedge clk) mem_dout <= mem_en ? bmem[mem_addr] : DW'($urandom());

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a run is L*N beats (or until the pass containing stop),
  // beat k carries word k%L and tlast when k%L == L-1.
  int cyc = 0;
  bit model_busy = 0;
  int m_L = 1, m_total = 0, iss = 0, acc = 0, model_pc = 0;
  int start_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0, n_beats_run = 0, n_done = 0;
  bit seen_vld = 0, done_exp = 0, prev_stall = 0, prev_last = 0;
  logic [DW-1:0] prev_dat = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_busy = 0; iss = 0; acc = 0; done_exp = 0; prev_stall = 0;
    end else begin
      check_val("busy", busy, model_busy);
      check_val("done", done, done_exp);
      check_val("pass_cnt", pass_cnt, model_pc);
      if (done) n_done++;
      done_exp = 0;
      if (prev_stall) begin
        check_val("stall_vld", m_tvalid, 1);
        check_val("stall_dat", m_tdata, prev_dat);
        check_val("stall_last", m_tlast, prev_last);
      end
      if (!model_busy) begin
        check_val("idle_mem_en", mem_en, 0);
        check_val("idle_tvalid", m_tvalid, 0);
        if (start && len != 0) begin
          model_busy = 1;
          m_L = (len > (1 << AW)) ? (1 << AW) : int'(len);
          m_total = (num_passes == 0) ? BIG : m_L * int'(num_passes);
          if (stop) m_total = m_L;
          iss = 0; acc = 0; model_pc = 0; n_beats_run = 0;
          start_cyc = cyc; seen_vld = 0;
        end
      end else begin
        if (stop && iss < m_total && ((iss / m_L) + 1) * m_L < m_total)
          m_total = ((iss / m_L) + 1) * m_L;
        if (mem_en) begin
          if (iss >= m_total) check_val("read_after_final", mem_en, 0);
          else begin
            check_val("mem_addr", mem_addr, iss % m_L);
            iss++;
            check_val("outstanding_le2", (iss - acc) <= 2, 1);
          end
        end
        if (m_tvalid && !seen_vld) begin
          seen_vld = 1;
          check_val("first_vld_lat", cyc - start_cyc, 2);
        end
        if (m_tvalid && m_tready) begin
          automatic int a = acc % m_L;
          check_val("tdata", m_tdata, bmem[a]);
          check_val("tlast", m_tlast, a == m_L - 1);
          if (a == m_L - 1 && model_pc < 65535) model_pc++;
          if (n_beats_run == 0) first_beat_cyc = cyc;
          last_beat_cyc = cyc;
          n_beats_run++;
          acc++;
          if (acc == m_total) begin
            model_busy = 0;
            done_exp = 1;
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int l, input int n, input bit s);
    len = (AW + 1)'(l); num_passes = 16'(n); stop = s; start = 1;
    tick();
    start = 0; stop = 0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while (model_busy && n < budget) begin
      if (rnd) begin
        m_tready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
          start = 1; len = (AW + 1)'($urandom_range(1, 31));
        end
      end
      tick();
      start = 0;
      n++;
    end
    if (model_busy) check_val("wait_timeout", busy, 0);
    m_tready = 1;
    tick(); tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int d0, l, n;
    bit s;
    rst_n = 0; start = 0; stop = 0; len = '0; num_passes = '0; m_tready = 1;
    for (int i = 0; i < (1 << AW); i++) bmem[i] = DW'($urandom());
    repeat (3) tick();
    check_val("rst_mem_en", mem_en, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_tdata", m_tdata, 0);
    check_val("rst_tvalid", m_tvalid, 0);
    check_val("rst_tlast", m_tlast, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pass_cnt", pass_cnt, 0);
    rst_n = 1;
    repeat (2) tick();

    // len=4, two passes, full throughput
    d0 = n_done;
    pulse_start(4, 2, 0);
    wait_idle(200, 0);
    check_val("s1_beats", n_beats_run, 8);
    check_val("s1_span", last_beat_cyc - first_beat_cyc, 7);
    check_val("s1_pass_cnt", pass_cnt, 2);
    check_val("s1_done_cnt", n_done - d0, 1);

    // len=8, one pass, random backpressure
    pulse_start(8, 1, 0);
    wait_idle(500, 1);
    check_val("s2_beats", n_beats_run, 8);
    check_val("s2_pass_cnt", pass_cnt, 1);

    // continuous, stop in the middle of pass 5
    d0 = n_done;
    pulse_start(3, 0, 0);
    for (int k = 0; k < 200 && iss < 13; k++) tick();
    check_val("s3_reach_pass5", iss >= 13, 1);
    stop = 1; tick(); stop = 0;
    wait_idle(200, 0);
    check_val("s3_beats", n_beats_run, 15);
    check_val("s3_pass_cnt", pass_cnt, 5);
    check_val("s3_busy", busy, 0);
    check_val("s3_done_cnt", n_done - d0, 1);

    // len=1, three passes
    pulse_start(1, 3, 0);
    wait_idle(100, 0);
    check_val("s4_beats", n_beats_run, 3);
    check_val("s4_pass_cnt", pass_cnt, 3);

    // len=0 is ignored
    pulse_start(0, 2, 0);
    repeat (5) tick();
    check_val("s5_busy", busy, 0);
    check_val("s5_mem_en", mem_en, 0);

    // len above depth is clamped
    pulse_start(31, 1, 0);
    wait_idle(200, 0);
    check_val("s6_clamp_beats", n_beats_run, 1 << AW);

    // start and stop together: one pass
    d0 = n_done;
    pulse_start(5, 0, 1);
    wait_idle(200, 0);
    check_val("s7_beats", n_beats_run, 5);
    check_val("s7_done_cnt", n_done - d0, 1);

    // reset mid-stream while stalled
    m_tready = 0;
    pulse_start(8, 2, 0);
    repeat (6) tick();
    check_val("s8_pre_rst_vld", m_tvalid, 1);
    rst_n = 0;
    #1;
    check_val("s8_rst_mem_en", mem_en, 0);
    check_val("s8_rst_mem_addr", mem_addr, 0);
    check_val("s8_rst_tdata", m_tdata, 0);
    check_val("s8_rst_tvalid", m_tvalid, 0);
    check_val("s8_rst_tlast", m_tlast, 0);
    check_val("s8_rst_busy", busy, 0);
    check_val("s8_rst_done", done, 0);
    check_val("s8_rst_pass_cnt", pass_cnt, 0);
    repeat (3) tick();
    rst_n = 1;
    d0 = n_done;
    m_tready = 1;
    repeat (4) tick();
    check_val("s8_no_done", n_done - d0, 0);
    check_val("s8_busy_after", busy, 0);
    pulse_start(4, 1, 0);
    wait_idle(200, 0);
    check_val("s8_replay_beats", n_beats_run, 4);

    // random runs with backpressure and ignored starts
    for (int r = 0; r < 6; r++) begin
      l = $urandom_range(1, 20);
      n = $urandom_range(1, 3);
      s = ($urandom_range(0, 3) == 0);
      d0 = n_done;
      pulse_start(l, n, s);
      wait_idle(1500, 1);
      check_val("rnd_beats", n_beats_run, (l > 16 ? 16 : l) * (s ? 1 : n));
      check_val("rnd_done_cnt", n_done - d0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
